// File: rtl/partial_sum_accumulator44_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding and default widths.
package partial_sum_accumulator44_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int ACC_W_DEF  = 44;
    localparam int TERM_W_DEF = 13;
    localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/customAdder44_31.sv
// 44-bit + 13-bit unsigned adder with a 45-bit sum (carry-out in the top bit).
module customAdder44_31 (
    input  logic [43:0] A,
    input  logic [12:0] B,
    output logic [44:0] Sum
);

    assign Sum = {1'b0, A} + {32'd0, B};

endmodule

// File: rtl/partial_sum_accumulator44.sv
// Accumulates term_count unsigned terms onto acc_init, reporting the wrapped sum
// and a sticky carry-out through a valid/ready result handshake.
module partial_sum_accumulator44
    import partial_sum_accumulator44_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int TERM_W = TERM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  term_count,
    input  logic [ACC_W-1:0]  acc_init,
    input  logic [TERM_W-1:0] term_in,
    input  logic              term_valid,
    output logic              term_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               overflow_q, overflow_d;
    logic [ACC_W:0]     sum;

    customAdder44_31 u_adder (
        .A   (acc_q),
        .B   (term_in),
        .Sum (sum)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = acc_init;
                    remaining_d = term_count;
                    overflow_d  = 1'b0;
                    state_d     = (term_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (term_valid) begin
                    acc_d       = sum[ACC_W-1:0];
                    overflow_d  = overflow_q | sum[ACC_W];
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the handoff cycle
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
        end
    end

    // All outputs decode from registered state only, so term_ready has no path from term_valid.
    assign term_ready   = (state_q == ACCUM);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign result       = acc_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/partial_sum_accumulator44.md
PARTIAL_SUM_ACCUMULATOR44 -- requirements
Module: partial_sum_accumulator44

Interface
REQ-001 The block SHALL have parameter ACC_W, default 44, meaning accumulator width.
REQ-002 The block SHALL have parameter TERM_W, default 13, meaning width of each incoming term.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning width of the term count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin an accumulation; sampled only in IDLE.
REQ-007 term_count  input  CNT_W  number of terms to accumulate; latched on accepted start.
REQ-008 acc_init  input  ACC_W  initial accumulator value; latched on accepted start.
REQ-009 term_in  input  TERM_W  unsigned term, zero-extended to ACC_W before the add.
REQ-010 term_valid  input  1  term_in is valid.
REQ-011 term_ready  output  1  block accepts a term this cycle.
REQ-012 result  output  ACC_W  final accumulator value; stable while result_valid=1.
REQ-013 overflow  output  1  sticky carry-out flag for the current accumulation.
REQ-014 result_valid  output  1  result and overflow are valid.
REQ-015 result_ready  input  1  downstream accepts the result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch acc_init into acc, latch term_count into remaining, and clear overflow.
REQ-019 In the same IDLE cycle, the FSM SHALL go to DONE if term_count=0 and to ACCUM otherwise.
REQ-020 In ACCUM, term_ready SHALL be 1; it SHALL be 0 in IDLE and DONE.
REQ-021 A term SHALL be accepted only on a cycle where term_valid=1 and term_ready=1; there SHALL be no combinational path from term_valid to term_ready.
REQ-022 On each accepted term, acc SHALL take sum[43:0], where sum = acc + zero-extended term_in (45 bits); the stored value wraps modulo 2^44.
REQ-023 On each accepted term, overflow SHALL be ORed with sum[44].
REQ-024 On each accepted term, remaining SHALL decrement by 1.
REQ-025 The FSM SHALL go from ACCUM to DONE on the cycle that accepts the term taken while remaining=1.
REQ-026 The block SHALL sustain one term per cycle; result_valid SHALL assert the cycle after the last term is accepted.
REQ-027 A cycle in ACCUM with term_valid=0 SHALL leave all state unchanged.
REQ-028 In DONE, result_valid SHALL be 1, with result=acc.
REQ-029 In DONE, result_valid=1 together with result_ready=1 SHALL move the FSM to IDLE; otherwise the block SHALL hold.
REQ-030 start SHALL be ignored in ACCUM and in DONE, including in the DONE-to-IDLE handoff cycle.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force FSM=IDLE, acc=0, remaining=0 and overflow=0.
REQ-032 While rst_n=0, the outputs SHALL be result=0, result_valid=0, term_ready=0, busy=0 and overflow=0.
REQ-033 A reset asserted mid-accumulation SHALL discard the partial sum; no result_valid pulse SHALL follow.
REQ-034 Reset deassertion SHALL be synchronized externally; the block SHALL not resynchronize it.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and the ACC_W, TERM_W and CNT_W default constants.
REQ-036 The addition SHALL be done by one instance of the team's existing 44-bit + 13-bit adder customAdder44_31, with the 45-bit Sum fed back into acc.
REQ-037 No other arithmetic sub-module SHALL be instantiated.

Verification
REQ-038 Basic sum: start with acc_init=0, count=3, terms 1, 2, 3 back-to-back -> result=6, overflow=0, result_valid exactly one cycle after the third accept.
REQ-039 Zero count: start with count=0, acc_init=0x123 -> result_valid the next cycle with result=0x123 and no term_ready pulse.
REQ-040 Wrap: acc_init=0xFFFFFFFFFFF, count=1, term=0x1FFF -> result=0x00000001FFE, overflow=1.
REQ-041 Backpressure: count=2, term_valid gaps of 3 cycles, then result_ready held low 5 cycles -> result stable throughout, and a start issued during DONE is ignored.
REQ-042 Reset mid-operation: assert rst_n=0 after 1 of 4 terms -> all outputs 0 immediately; a new start after release yields a correct independent sum.
